// File: rtl/hex_display_driver_pkg.sv
// Shared constants for the hex display driver.
//   SEG_BLANK    : active-low pattern with every segment dark
//   SEG_PATTERNS : 16-entry active-low glyph table, index = nibble, bit0=a .. bit6=g
//   clog2        : ceiling log2, used to size the blink divider
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hex7seg_lut.sv
// Combinational nibble to active-low 7-segment lookup.
//   nibble_i : 4-bit hex digit
//   seg_o    : active-low segments, bit0=a .. bit6=g
module hex7seg_lut
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_PATTERNS[nibble_i];

endmodule

// File: rtl/hex_display_driver.sv
// Registered driver for NUM_DIGITS active-low 7-segment digits.
// Latches value/enable/blink masks on load_i, applies leading-zero blanking
// and blinking from a free-running divider, and registers the final segments.
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   load_i       : capture value_i, en_mask_i, blink_mask_i this edge
//   value_i      : packed nibbles, digit 0 = bits [3:0]
//   en_mask_i    : 1 = digit enabled, 0 = forced blank
//   blink_mask_i : 1 = digit blinks
//   lz_blank_i   : 1 = blank leading zero digits (level, sampled each edge)
//   seg_o        : active-low segments, digit d at [7d+6:7d]
//   blink_ph_o   : blink phase, 1 = blinking digits dark
module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_HALF = 25000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_i,
  input  logic [4*NUM_DIGITS-1:0]   value_i,
  input  logic [NUM_DIGITS-1:0]     en_mask_i,
  input  logic [NUM_DIGITS-1:0]     blink_mask_i,
  input  logic                      lz_blank_i,
  output logic [7*NUM_DIGITS-1:0]   seg_o,
  output logic                      blink_ph_o
);

  localparam int VW     = 4 * NUM_DIGITS;
  localparam int SW     = 7 * NUM_DIGITS;
  localparam int CW_RAW = clog2(BLINK_HALF);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_HALF - 1);

  logic [VW-1:0]         value_q, value_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [NUM_DIGITS-1:0] blink_q, blink_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [SW-1:0]         seg_q, seg_d;
  logic                  wrap;

  always_comb begin
    value_d = value_q;
    en_d    = en_q;
    blink_d = blink_q;
    if (load_i) begin
      value_d = value_i;
      en_d    = en_mask_i;
      blink_d = blink_mask_i;
    end
  end

  // Free-running divider; a load never disturbs it.
  always_comb begin
    wrap    = (cnt_q == CNT_MAX);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    phase_d = phase_q ^ wrap;
  end

  // Segments are computed from next-state values so a load (and a phase
  // change on the same edge) shows up on seg_o at that very edge.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [6:0] pat;
      logic       lz_dark;
      logic       dark;

      hex7seg_lut u_lut (
        .nibble_i (value_d[4*gi +: 4]),
        .seg_o    (pat)
      );

      if (gi == 0) begin : g_lsd
        // The least significant digit always shows, so zero reads as "0".
        assign lz_dark = 1'b0;
      end else begin : g_upper
        // Blank when this nibble and every nibble above it are zero.
        assign lz_dark = lz_blank_i && (value_d[VW-1:4*gi] == '0);
      end

      assign dark = !en_d[gi] || (blink_d[gi] && phase_d) || lz_dark;
      assign seg_d[7*gi +: 7] = dark ? SEG_BLANK : pat;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      en_q    <= '0;
      blink_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      seg_q   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      value_q <= value_d;
      en_q    <= en_d;
      blink_q <= blink_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
    end
  end

  assign seg_o      = seg_q;
  assign blink_ph_o = phase_q;

endmodule

// File: tb/tb_hex_display_driver.sv
module tb_hex_display_driver;

  localparam int ND = 4;
  localparam int BH = 4;

  logic          clk;
  logic          rst_n;
  logic          load_i;
  logic [15:0]   value_i;
  logic [3:0]    en_mask_i;
  logic [3:0]    blink_mask_i;
  logic          lz_blank_i;
  logic [27:0]   seg_o;
  logic          blink_ph_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference glyphs (active-low, g..a), index = hex digit.
  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Behavioural model state: what the display was last told, and how many
  // clock edges have elapsed since reset was released.
  int unsigned m_val;
  int unsigned m_en;
  int unsigned m_blink;
  int unsigned m_lz;
  int unsigned m_n;

  hex_display_driver #(.NUM_DIGITS(ND), .BLINK_HALF(BH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load_i),
    .value_i      (value_i),
    .en_mask_i    (en_mask_i),
    .blink_mask_i (blink_mask_i),
    .lz_blank_i   (lz_blank_i),
    .seg_o        (seg_o),
    .blink_ph_o   (blink_ph_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase flips once every BH edges after reset release.
  function automatic logic model_phase();
    return ((m_n / BH) % 2) == 1;
  endfunction

  function automatic logic [27:0] model_seg();
    logic [27:0] r;
    logic        ph;
    ph = model_phase();
    r  = '0;
    for (int d = 0; d < ND; d++) begin
      int unsigned nib;
      int unsigned upper;
      logic        dark;
      nib   = (m_val >> (4 * d)) % 16;
      upper = m_val >> (4 * d);
      dark  = (((m_en >> d) & 1) == 0) ||
              ((((m_blink >> d) & 1) == 1) && ph) ||
              ((m_lz == 1) && (d > 0) && (upper == 0));
      r[7*d +: 7] = dark ? 7'h7F : glyph[nib];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val = 0; m_en = 0; m_blink = 0; m_lz = 0; m_n = 0;
  endtask

  // Drive one edge's worth of inputs, advance the clock, update the model,
  // and leave time 1 unit past the edge for sampling.
  task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] en,
                       input logic [3:0] bl, input logic lz);
    load_i = ld; value_i = v; en_mask_i = en; blink_mask_i = bl; lz_blank_i = lz;
    @(posedge clk);
    if (ld) begin
      m_val = v; m_en = en; m_blink = bl;
    end
    m_lz = lz;
    m_n  = m_n + 1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load_i = 1'b0; value_i = '0; en_mask_i = '0; blink_mask_i = '0; lz_blank_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (seg_o !== 28'hFFFFFFF) $display("FAIL reset_seg: got %h want %h", seg_o, 28'hFFFFFFF);
    else n_pass++;
    n_checks++;
    if (blink_ph_o !== 1'b0) $display("FAIL reset_ph: got %b want 0", blink_ph_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b0, 16'hFFFF, 4'hF, 4'hF, 1'b0);
    n_checks++;
    if (seg_o !== 28'hFFFFFFF) $display("FAIL reset_first_edge: got %h want %h", seg_o, 28'hFFFFFFF);
    else n_pass++;
    $display("reset: seg=%h ph=%b", seg_o, blink_ph_o);
  endtask

  task automatic test_decode();
    logic [27:0] want;
    cycle(1'b1, 16'h12AF, 4'hF, 4'h0, 1'b0);
    want = {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110};
    n_checks++;
    if (seg_o !== want) $display("FAIL decode_12AF: got %h want %h", seg_o, want);
    else n_pass++;
    $display("decode 12AF: seg=%h", seg_o);
    // Without load the registers hold even though the inputs change.
    cycle(1'b0, 16'h0000, 4'h0, 4'hF, 1'b0);
    n_checks++;
    if (seg_o !== want) $display("FAIL decode_hold: got %h want %h", seg_o, want);
    else n_pass++;
    $display("hold: seg=%h", seg_o);
  endtask

  task automatic test_lz_blank();
    logic [27:0] want;
    cycle(1'b1, 16'h0050, 4'hF, 4'h0, 1'b1);
    want = {7'h7F, 7'h7F, 7'b0010010, 7'b1000000};
    n_checks++;
    if (seg_o !== want) $display("FAIL lz_0050: got %h want %h", seg_o, want);
    else n_pass++;
    $display("lz 0050: seg=%h", seg_o);
    cycle(1'b1, 16'h0000, 4'hF, 4'h0, 1'b1);
    want = {7'h7F, 7'h7F, 7'h7F, 7'b1000000};
    n_checks++;
    if (seg_o !== want) $display("FAIL lz_0000: got %h want %h", seg_o, want);
    else n_pass++;
    $display("lz 0000: seg=%h", seg_o);
    // lz_blank_i is a level: dropping it reveals the zeros with no load.
    cycle(1'b0, 16'hFFFF, 4'h0, 4'h0, 1'b0);
    want = {4{7'b1000000}};
    n_checks++;
    if (seg_o !== want) $display("FAIL lz_level: got %h want %h", seg_o, want);
    else n_pass++;
    $display("lz off: seg=%h", seg_o);
  endtask

  task automatic test_enable();
    logic [27:0] want;
    cycle(1'b1, 16'h8888, 4'b1010, 4'h0, 1'b0);
    want = {7'b0000000, 7'h7F, 7'b0000000, 7'h7F};
    n_checks++;
    if (seg_o !== want) $display("FAIL enable_mask: got %h want %h", seg_o, want);
    else n_pass++;
    $display("enable 1010: seg=%h", seg_o);
  endtask

  task automatic test_blink();
    logic [6:0] want0;
    cycle(1'b1, 16'h0008, 4'hF, 4'b0001, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      want0 = model_phase() ? 7'h7F : 7'b0000000;
      n_checks++;
      if (seg_o[6:0] !== want0) $display("FAIL blink_d0: got %b want %b", seg_o[6:0], want0);
      else n_pass++;
      n_checks++;
      if (seg_o[27:7] !== {3{7'b1000000}}) $display("FAIL blink_steady: got %h want %h", seg_o[27:7], {3{7'b1000000}});
      else n_pass++;
      n_checks++;
      if (blink_ph_o !== model_phase()) $display("FAIL blink_ph: got %b want %b", blink_ph_o, model_phase());
      else n_pass++;
      $display("blink %0d: d0=%b ph=%b", i, seg_o[6:0], blink_ph_o);
    end
  endtask

  task automatic test_load_on_wrap();
    logic        ph_before;
    logic [27:0] want;
    for (int k = 0; k < 2; k++) begin
      for (int g = 0; g < 2 * BH && ((m_n + 1) % BH) != 0; g++)
        cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      n_checks++;
      if (((m_n + 1) % BH) != 0) $display("FAIL wrap_align: got %0d want %0d", (m_n + 1) % BH, 0);
      else n_pass++;
      ph_before = blink_ph_o;
      cycle(1'b1, 16'h3C5A, 4'hF, 4'b0110, 1'b0);
      n_checks++;
      if (blink_ph_o !== ~ph_before) $display("FAIL wrap_ph: got %b want %b", blink_ph_o, ~ph_before);
      else n_pass++;
      want = ph_before ? {7'b0110000, 7'b1000110, 7'b0010010, 7'b0001000}
                       : {7'b0110000, 7'h7F, 7'h7F, 7'b0001000};
      n_checks++;
      if (seg_o !== want) $display("FAIL wrap_seg: got %h want %h", seg_o, want);
      else n_pass++;
      $display("load on wrap: seg=%h ph=%b", seg_o, blink_ph_o);
    end
  endtask

  task automatic test_random();
    logic [27:0] want;
    for (int i = 0; i < 200; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      // Bias toward leading zeros so blanking gets exercised.
      case ($urandom_range(0, 3))
        0: v = v & 16'h00FF;
        1: v = v & 16'h000F;
        default: ;
      endcase
      cycle(($urandom_range(0, 2) == 0), v, 4'($urandom), 4'($urandom), 1'($urandom));
      want = model_seg();
      n_checks++;
      if (seg_o !== want) $display("FAIL rand_seg %0d: got %h want %h", i, seg_o, want);
      else n_pass++;
      n_checks++;
      if (blink_ph_o !== model_phase()) $display("FAIL rand_ph %0d: got %b want %b", i, blink_ph_o, model_phase());
      else n_pass++;
      $display("rand %0d: ld=%b v=%h en=%h bl=%h lz=%b seg=%h ph=%b",
               i, load_i, value_i, en_mask_i, blink_mask_i, lz_blank_i, seg_o, blink_ph_o);
    end
  endtask

  task automatic test_midrun_reset();
    logic [27:0] want;
    cycle(1'b1, 16'h4321, 4'hF, 4'h0, 1'b0);
    cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (seg_o !== 28'hFFFFFFF) $display("FAIL midreset_seg: got %h want %h", seg_o, 28'hFFFFFFF);
    else n_pass++;
    n_checks++;
    if (blink_ph_o !== 1'b0) $display("FAIL midreset_ph: got %b want 0", blink_ph_o);
    else n_pass++;
    $display("mid-run reset: seg=%h ph=%b", seg_o, blink_ph_o);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // Counter restarts: phase stays 0 for BH-1 edges then flips on edge BH.
    for (int i = 0; i < 2 * BH; i++) begin
      cycle(1'b1, 16'h00A7, 4'hF, 4'hF, 1'b0);
      want = model_seg();
      n_checks++;
      if (blink_ph_o !== model_phase()) $display("FAIL restart_ph %0d: got %b want %b", i, blink_ph_o, model_phase());
      else n_pass++;
      n_checks++;
      if (seg_o !== want) $display("FAIL restart_seg %0d: got %h want %h", i, seg_o, want);
      else n_pass++;
      $display("restart %0d: seg=%h ph=%b", i, seg_o, blink_ph_o);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_decode();
    test_lz_blank();
    test_enable();
    test_blink();
    test_load_on_wrap();
    test_random();
    test_midrun_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
